// File: rtl/axilite_master_if.sv
// AXI4-Lite bus bundle between the command engine (master) and a CSR slave.
interface axilite_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axilite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one response out.
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W issued, each drops after its own handshake
// WR_RESP | BREADY high, waiting for B
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_RESP | RREADY high, waiting for R
// RSP     | rsp_valid high until rsp_ready
module axilite_master #(
  parameter int         ADDR_W    = 16,
  parameter int         DATA_W    = 32,
  parameter logic [2:0] PROT      = 3'b000,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  input  logic [DATA_W/8-1:0]  cmd_wstrb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy,
  axilite_master_if.master     axi
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic              cap;
  logic [1:0]        cap_resp;

  assign axi.AWADDR  = addr_q;
  assign axi.ARADDR  = addr_q;
  assign axi.AWPROT  = PROT;
  assign axi.ARPROT  = PROT;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.AWVALID = aw_valid;
  assign axi.WVALID  = w_valid;
  assign axi.BREADY  = b_ready;
  assign axi.ARVALID = ar_valid;
  assign axi.RREADY  = r_ready;
  assign busy        = (state != IDLE);

  always_comb begin
    cap      = 1'b0;
    cap_resp = 2'b00;
    if (state == WR_RESP && axi.BVALID) begin
      cap      = 1'b1;
      cap_resp = axi.BRESP;
    end else if (state == RD_RESP && axi.RVALID) begin
      cap      = 1'b1;
      cap_resp = axi.RRESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      b_ready   <= 1'b0;
      ar_valid  <= 1'b0;
      r_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            if (cmd_write) begin
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= WR_REQ;
            end else begin
              ar_valid <= 1'b1;
              state    <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_REQ: begin
          // a channel counts as done once its VALID is low or handshakes now
          if (axi.AWREADY) aw_valid <= 1'b0;
          if (axi.WREADY)  w_valid  <= 1'b0;
          if ((!aw_valid || axi.AWREADY) && (!w_valid || axi.WREADY)) begin
            b_ready <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (cap) begin
            b_ready   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= cap_resp;
            state     <= RSP;
          end
        end
        RD_REQ: begin
          if (axi.ARREADY) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (cap) begin
            r_ready   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= axi.RDATA;
            rsp_resp  <= cap_resp;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (cap && cap_resp != 2'b00 && err_cnt != '1)
        err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end
endmodule

// File: doc/axilite_master.md
Name: axilite_master

Overview:
- Synthesizable AXI4-Lite master engine that converts a simple single-beat command/response port into AXI4-Lite read and write transactions.
- Intended for on-chip sequencers and test harnesses that must drive CSR maps generated by the codebase without a processor.
- Extends the plain interface with:
  - parametrised widths and protection bits;
  - concurrent AW/W issue;
  - response back-pressure;
  - a saturating error counter.

Parameters:
- ADDR_W, 16, address width of cmd_addr, AWADDR and ARADDR.
- DATA_W, 32, data width; must be 32 or 64.
- STRB_W, DATA_W/8, write strobe width; derived, not overridden.
- PROT, 3'b000, constant value driven on AWPROT and ARPROT.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transaction address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_wstrb  in  STRB_W  write strobes; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echoes cmd_write of the completed transaction.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- err_cnt  out  ERR_CNT_W  count of responses with resp != 2'b00, saturating.
- busy  out  1  high whenever state != IDLE.
- AWADDR  out  ADDR_W.
- AWPROT  out  3.
- AWVALID  out  1.
- AWREADY  in  1.
- WDATA  out  DATA_W.
- WSTRB  out  STRB_W.
- WVALID  out  1.
- WREADY  in  1.
- BRESP  in  2.
- BVALID  in  1.
- BREADY  out  1.
- ARADDR  out  ADDR_W.
- ARPROT  out  3.
- ARVALID  out  1.
- ARREADY  in  1.
- RDATA  in  DATA_W.
- RRESP  in  2.
- RVALID  in  1.
- RREADY  out  1.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all VALID/READY outputs 0; rsp_valid 0; busy 0; err_cnt 0; addr/data/strb/rdata/resp registers 0; state IDLE.
- cmd_ready is 1 only in IDLE and is not asserted during rst.
- AWPROT and ARPROT are always PROT.
- All AXI outputs are registered; no combinational path from any input to any output.
- At most one transaction is outstanding.
- State machine and transitions:
  - IDLE: on cmd handshake, latch cmd fields.
    - Write: go to WR_REQ; AWVALID and WVALID both go 1 in the next cycle.
    - Read: go to RD_REQ; ARVALID goes 1 in the next cycle.
  - WR_REQ: AW and W complete independently.
    - AWVALID drops in the cycle after a cycle with AWVALID && AWREADY.
    - WVALID drops in the cycle after a cycle with WVALID && WREADY.
    - AWADDR, WDATA and WSTRB hold stable while the corresponding VALID is high.
    - When both handshakes have completed (same cycle or different cycles), go to WR_RESP; BREADY goes 1.
  - WR_RESP: BREADY stays 1 until the first cycle with BVALID && BREADY.
    - Capture BRESP into rsp_resp; set rsp_write 1 and rsp_rdata 0.
    - BREADY drops next cycle; go to RSP.
  - RD_REQ: ARVALID holds until the ARVALID && ARREADY cycle, drops next cycle; go to RD_RESP with RREADY 1.
  - RD_RESP: on RVALID && RREADY, capture RDATA and RRESP; set rsp_write 0; RREADY drops; go to RSP.
  - RSP: rsp_valid 1; rsp fields hold stable until rsp_ready. On handshake, rsp_valid drops and state returns to IDLE.
- Back-pressure: B and R are not accepted until the engine is in WR_RESP or RD_RESP; an early BVALID/RVALID simply waits.
- Minimum latency, write with AWREADY, WREADY and BVALID held 1:
  - cmd accepted at cycle 0;
  - AW/W handshake at cycle 1;
  - B handshake at cycle 2;
  - rsp_valid at cycle 3;
  - cmd_ready again at cycle 4 if rsp_ready is 1.
- Reads follow the same timing.
- err_cnt increments by 1 when a response is captured with resp != 00 (SLVERR or DECERR). It saturates at all-ones and has no wrap.
- Reset mid-transaction: all VALID/READY outputs deassert in the cycle after rst is sampled high, any pending response is discarded, and err_cnt clears. The bench must also reset the slave.

Test Plan:
- Write 0x0004 / 0xDEADBEEF / strb 4'hF with an always-ready slave that returns OKAY:
  - AWVALID and WVALID rise together at cycle 1;
  - rsp_valid at cycle 3 with rsp_write 1 and rsp_resp 00;
  - err_cnt stays 0.
- Write with AWREADY delayed 3 cycles and WREADY delayed 1 cycle:
  - WVALID drops 2 cycles before AWVALID;
  - BREADY rises only after both handshakes;
  - AWADDR and WDATA stay stable throughout.
- Read 0x0010 where the slave returns 0x12345678 / RRESP 00 after 5 cycles:
  - rsp_rdata 0x12345678, rsp_write 0;
  - RREADY drops the cycle after the handshake.
- rsp_ready held 0 for 10 cycles after completion:
  - rsp_valid and rsp fields stay stable;
  - cmd_ready stays 0 and a new cmd_valid is not accepted until rsp_ready goes 1.
- 300 consecutive reads returning SLVERR (10) with ERR_CNT_W = 8: err_cnt saturates at 255.
- rst asserted while in WR_REQ with AWVALID = 1:
  - next cycle all AXI VALID/READY are 0, busy 0, err_cnt 0;
  - cmd_ready is 1 after rst is released.
